// File: rtl/delta_change_monitor.sv
// Samples an 8-bit counter bus, queues every value change in a small FIFO
// and checks +1 steps. Optional macro: DELTA_STEP_CHECK_EN (step-error tracking).
module delta_change_monitor #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       x_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_data,
  output logic             evt_step_err,
  output logic [CNT_W-1:0] change_count,
  output logic             overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  typedef enum logic {PRIME = 1'b0, RUN = 1'b1} state_t;

  state_t        state;
  state_t        state_next;
  logic [7:0]    prev;
  logic [7:0]    data_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic          load_prev;
  logic          change;
  logic          push;
  logic          pop;
  logic          drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PRIME;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_prev  = 1'b0;
    change     = 1'b0;
    case (state)
      PRIME: begin
        load_prev  = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        change    = (x_in != prev);
        load_prev = change;
      end
      default: begin
        state_next = PRIME;
      end
    endcase
  end

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign pop  = (occ != {(AW+1){1'b0}}) && evt_ready;
  assign push = change && ((occ != FULL_OCC) || pop);
  assign drop = change && (occ == FULL_OCC) && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev         <= 8'h00;
      wr_ptr       <= {AW{1'b0}};
      rd_ptr       <= {AW{1'b0}};
      occ          <= {(AW+1){1'b0}};
      change_count <= {CNT_W{1'b0}};
      overflow     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= 8'h00;
      end
    end else begin
      if (load_prev) begin
        prev <= x_in;
      end
      if (push) begin
        data_mem[wr_ptr] <= x_in;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        occ <= occ + (AW+1)'(1);
      end else if (pop && !push) begin
        occ <= occ - (AW+1)'(1);
      end
      if (change && (change_count != {CNT_W{1'b1}})) begin
        change_count <= change_count + CNT_W'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign evt_valid = (occ != {(AW+1){1'b0}});
  assign evt_data  = data_mem[rd_ptr];

`ifdef DELTA_STEP_CHECK_EN
  logic err_mem [DEPTH];
  logic step_err;

  // Step error is judged against the last sampled value only.
  assign step_err = (x_in != (prev + 8'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        err_mem[i] <= 1'b0;
      end
    end else if (push) begin
      err_mem[wr_ptr] <= step_err;
    end
  end

  assign evt_step_err = err_mem[rd_ptr];
`else
  assign evt_step_err = 1'b0;
`endif

endmodule

// File: tb/tb_delta_change_monitor.sv
// Self-checking bench for delta_change_monitor: directed test-plan scenarios
// plus randomized traffic compared against a queue-based event model.
module tb_delta_change_monitor;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
`ifdef DELTA_STEP_CHECK_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic [7:0]       x_in;
  logic             evt_valid;
  logic             evt_ready;
  logic [7:0]       evt_data;
  logic             evt_step_err;
  logic [CNT_W-1:0] change_count;
  logic             overflow;

  int checks;
  int errors;

  // Reference model: a queue of {step_err, data} events.
  logic [8:0] mq[$];
  logic [7:0] m_prev;
  bit         m_primed;
  int         m_count;
  bit         m_ovf;

  delta_change_monitor #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .x_in(x_in),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .evt_step_err(evt_step_err), .change_count(change_count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_edge(input logic [7:0] x, input bit r, input bit rs);
    int  sz;
    bit  do_pop;
    logic [7:0] nxt;
    if (rs) begin
      mq.delete();
      m_prev = 8'h00; m_primed = 1'b0; m_count = 0; m_ovf = 1'b0;
    end else if (!m_primed) begin
      m_prev = x; m_primed = 1'b1;
    end else begin
      sz = mq.size();
      do_pop = (sz > 0) && r;
      if (do_pop) void'(mq.pop_front());
      if (x != m_prev) begin
        nxt = m_prev + 8'd1;
        if (m_count < 65535) m_count++;
        if (sz == DEPTH && !do_pop) m_ovf = 1'b1;
        else mq.push_back({(STEP_EN && (x != nxt)), x});
        m_prev = x;
      end
    end
  endtask

  task automatic cycle(input logic [7:0] x, input bit r, input bit rs);
    x_in = x; evt_ready = r; rst = rs;
    @(posedge clk);
    model_edge(x, r, rs);
    @(negedge clk);
  endtask

  task automatic test_reset();
    cycle(8'h00, 1'b0, 1'b1);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid act=%b exp=0", evt_valid); end
    checks++; if (evt_data !== 8'h00) begin errors++; $display("FAIL reset_data act=%h exp=00", evt_data); end
    checks++; if (evt_step_err !== 1'b0) begin errors++; $display("FAIL reset_err act=%b exp=0", evt_step_err); end
    checks++; if (change_count !== 16'd0) begin errors++; $display("FAIL reset_count act=%0d exp=0", change_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf act=%b exp=0", overflow); end
  endtask

  task automatic test_increment();
    logic [7:0] v;
    cycle(8'h00, 1'b1, 1'b1);
    cycle(8'h00, 1'b1, 1'b0);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL inc_prime_valid act=%b exp=0", evt_valid); end
    for (int i = 1; i <= 3; i++) begin
      v = 8'(i);
      cycle(v, 1'b1, 1'b0);
      checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL inc_valid act=%b exp=1", evt_valid); end
      checks++; if (evt_data !== v) begin errors++; $display("FAIL inc_data act=%h exp=%h", evt_data, v); end
      checks++; if (evt_step_err !== 1'b0) begin errors++; $display("FAIL inc_err act=%b exp=0", evt_step_err); end
    end
    cycle(8'h03, 1'b1, 1'b0);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL inc_drained act=%b exp=0", evt_valid); end
    checks++; if (change_count !== 16'd3) begin errors++; $display("FAIL inc_count act=%0d exp=3", change_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL inc_ovf act=%b exp=0", overflow); end
  endtask

  task automatic test_wrap();
    cycle(8'hFE, 1'b1, 1'b1);
    cycle(8'hFE, 1'b1, 1'b0);
    cycle(8'hFF, 1'b1, 1'b0);
    checks++; if (evt_data !== 8'hFF || evt_valid !== 1'b1) begin errors++; $display("FAIL wrap_ff act=%b/%h exp=1/ff", evt_valid, evt_data); end
    checks++; if (evt_step_err !== 1'b0) begin errors++; $display("FAIL wrap_ff_err act=%b exp=0", evt_step_err); end
    cycle(8'h00, 1'b1, 1'b0);
    checks++; if (evt_data !== 8'h00 || evt_valid !== 1'b1) begin errors++; $display("FAIL wrap_00 act=%b/%h exp=1/00", evt_valid, evt_data); end
    checks++; if (evt_step_err !== 1'b0) begin errors++; $display("FAIL wrap_00_err act=%b exp=0", evt_step_err); end
    checks++; if (change_count !== 16'd2) begin errors++; $display("FAIL wrap_count act=%0d exp=2", change_count); end
  endtask

  task automatic test_jump();
    cycle(8'h05, 1'b0, 1'b1);
    cycle(8'h05, 1'b0, 1'b0);
    cycle(8'h09, 1'b0, 1'b0);
    checks++; if (evt_data !== 8'h09 || evt_valid !== 1'b1) begin errors++; $display("FAIL jump_data act=%b/%h exp=1/09", evt_valid, evt_data); end
    checks++; if (evt_step_err !== STEP_EN) begin errors++; $display("FAIL jump_err act=%b exp=%b", evt_step_err, STEP_EN); end
    checks++; if (change_count !== 16'd1) begin errors++; $display("FAIL jump_count act=%0d exp=1", change_count); end
  endtask

  task automatic test_overflow();
    logic [7:0] v;
    cycle(8'h10, 1'b0, 1'b1);
    cycle(8'h10, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      cycle(8'h10 + 8'(i), 1'b0, 1'b0);
      checks++; if (evt_valid !== 1'b1 || evt_data !== 8'h11) begin errors++; $display("FAIL ovf_head act=%b/%h exp=1/11", evt_valid, evt_data); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag act=%b exp=1", overflow); end
    checks++; if (change_count !== 16'd5) begin errors++; $display("FAIL ovf_count act=%0d exp=5", change_count); end
    for (int i = 0; i < 4; i++) begin
      v = 8'h11 + 8'(i);
      checks++; if (evt_valid !== 1'b1 || evt_data !== v) begin errors++; $display("FAIL ovf_drain act=%b/%h exp=1/%h", evt_valid, evt_data, v); end
      cycle(8'h15, 1'b1, 1'b0);
    end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty act=%b exp=0", evt_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky act=%b exp=1", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] v;
    cycle(8'h20, 1'b0, 1'b1);
    cycle(8'h20, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) cycle(8'h20 + 8'(i), 1'b0, 1'b0);
    cycle(8'h25, 1'b1, 1'b0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_ovf act=%b exp=0", overflow); end
    for (int i = 0; i < 4; i++) begin
      v = 8'h22 + 8'(i);
      checks++; if (evt_valid !== 1'b1 || evt_data !== v) begin errors++; $display("FAIL full_drain act=%b/%h exp=1/%h", evt_valid, evt_data, v); end
      cycle(8'h25, 1'b1, 1'b0);
    end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL full_empty act=%b exp=0", evt_valid); end
    checks++; if (change_count !== 16'd5) begin errors++; $display("FAIL full_count act=%0d exp=5", change_count); end
  endtask

  task automatic test_mid_reset();
    cycle(8'h30, 1'b0, 1'b1);
    cycle(8'h30, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) cycle(8'h30 + 8'(i), 1'b0, 1'b0);
    checks++; if (evt_valid !== 1'b1 || change_count !== 16'd3) begin errors++; $display("FAIL mrst_pre act=%b/%0d exp=1/3", evt_valid, change_count); end
    cycle(8'h33, 1'b0, 1'b1);
    checks++; if (evt_valid !== 1'b0 || change_count !== 16'd0) begin errors++; $display("FAIL mrst_flush act=%b/%0d exp=0/0", evt_valid, change_count); end
    cycle(8'h40, 1'b0, 1'b0);
    checks++; if (evt_valid !== 1'b0 || change_count !== 16'd0) begin errors++; $display("FAIL mrst_prime act=%b/%0d exp=0/0", evt_valid, change_count); end
    cycle(8'h41, 1'b0, 1'b0);
    checks++; if (evt_valid !== 1'b1 || evt_data !== 8'h41) begin errors++; $display("FAIL mrst_evt act=%b/%h exp=1/41", evt_valid, evt_data); end
    checks++; if (change_count !== 16'd1) begin errors++; $display("FAIL mrst_count act=%0d exp=1", change_count); end
  endtask

  task automatic test_random();
    logic [7:0] cur;
    bit r;
    int sel;
    cur = 8'h00;
    cycle(cur, 1'b1, 1'b1);
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 9);
      if (sel > 6) cur = 8'($urandom_range(0, 255));
      else if (sel > 2) cur = cur + 8'd1;
      if ((n % 40) < 20) r = ($urandom_range(0, 3) != 0);
      else r = ($urandom_range(0, 3) == 0);
      cycle(cur, r, ($urandom_range(0, 149) == 0));
      checks++; if (evt_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid n=%0d act=%b exp=%b", n, evt_valid, (mq.size() != 0)); end
      if (mq.size() != 0) begin
        checks++; if (evt_data !== mq[0][7:0]) begin errors++; $display("FAIL rnd_data n=%0d act=%h exp=%h", n, evt_data, mq[0][7:0]); end
        checks++; if (evt_step_err !== mq[0][8]) begin errors++; $display("FAIL rnd_err n=%0d act=%b exp=%b", n, evt_step_err, mq[0][8]); end
      end
      checks++; if (change_count !== CNT_W'(m_count)) begin errors++; $display("FAIL rnd_count n=%0d act=%0d exp=%0d", n, change_count, m_count); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf n=%0d act=%b exp=%b", n, overflow, m_ovf); end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    m_prev = 8'h00; m_primed = 1'b0; m_count = 0; m_ovf = 1'b0;
    rst = 1'b1; x_in = 8'h00; evt_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_increment();
    test_wrap();
    test_jump();
    test_overflow();
    test_full_push_pop();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
